// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types, address map and transfer helpers for the memory subsystem.
package ahb_lite_pkg;

    localparam int MEM_WORDS = 256;
    localparam int NUM_MEM   = 2;

    localparam logic [31:0] MEM0_BASE  = 32'h0000_0000;
    localparam logic [31:0] MEM0_LIMIT = 32'h0000_03FF;
    localparam logic [31:0] MEM1_BASE  = 32'h0000_0400;
    localparam logic [31:0] MEM1_LIMIT = 32'h0000_07FF;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        SEL_MEM0    = 2'd0,
        SEL_MEM1    = 2'd1,
        SEL_DEFAULT = 2'd2,
        SEL_NONE    = 2'd3
    } sel_t;

    typedef enum logic {
        RSP_OK   = 1'b0,
        RSP_ERR2 = 1'b1
    } rsp_state_t;

    // Little-endian lane enables; unsupported sizes enable nothing.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << addr;
            HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: byte_en = 4'b1111;
            default:    byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic size_align_err(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: size_align_err = 1'b0;
            HSIZE_HALF: size_align_err = addr[0];
            HSIZE_WORD: size_align_err = |addr;
            default:    size_align_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_mem_slave.sv
// Zero-wait-state SRAM slave: captures the address phase, then writes selected
// byte lanes or presents the addressed word during the following data phase.
module ahb_mem_slave
    import ahb_lite_pkg::*;
#(
    parameter int WORDS = MEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel_i,
    input  logic        hready_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [9:0]  haddr_i,
    input  logic [31:0] hwdata_i,
    output logic [31:0] hrdata_o,
    output logic        hreadyout_o,
    output logic        hresp_o
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem_q [WORDS];
    logic          wr_q;
    logic [3:0]    be_q;
    logic [AW-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= 1'b0;
            be_q  <= 4'b0000;
            idx_q <= '0;
            for (int w = 0; w < WORDS; w++) begin
                mem_q[w] <= 32'h0;
            end
        end else begin
            // Commit first so a read captured on this same edge sees the new word.
            if (wr_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_q[b]) begin
                        mem_q[idx_q][8*b +: 8] <= hwdata_i[8*b +: 8];
                    end
                end
            end
            if (hready_i) begin
                wr_q  <= hsel_i && hwrite_i;
                be_q  <= byte_en(hsize_i, haddr_i[1:0]);
                idx_q <= haddr_i[AW+1:2];
            end
        end
    end

    assign hrdata_o    = mem_q[idx_q];
    assign hreadyout_o = 1'b1;
    assign hresp_o     = HRESP_OKAY;

endmodule

// File: rtl/ahb_lite_mem_subsystem.sv
// AHB-Lite slave subsystem: address decode, data-phase select register and
// response mux in front of two SRAM slaves plus a two-cycle error responder.
module ahb_lite_mem_subsystem
    import ahb_lite_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    logic        addr_active;
    sel_t        addr_sel;
    sel_t        sel_q;
    logic        write_q;
    rsp_state_t  rsp_q;
    rsp_state_t  rsp_d;

    logic [31:0]        mem_rdata [NUM_MEM];
    logic [NUM_MEM-1:0] mem_ready;
    logic [NUM_MEM-1:0] mem_resp;

    // Bursts are address-driven by the master, so HBURST carries no information here.
    logic unused_hburst;
    assign unused_hburst = ^HBURST;

    assign addr_active = HREADY &&
                         ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    always_comb begin
        addr_sel = SEL_NONE;
        if (addr_active) begin
            if (HADDR <= MEM0_LIMIT) begin
                addr_sel = SEL_MEM0;
            end else if ((HADDR >= MEM1_BASE) && (HADDR <= MEM1_LIMIT)) begin
                addr_sel = SEL_MEM1;
            end else begin
                addr_sel = SEL_DEFAULT;
            end
            // Illegal size/alignment is answered by the error responder, never by SRAM.
            if (size_align_err(HSIZE, HADDR[1:0])) begin
                addr_sel = SEL_DEFAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= SEL_NONE;
            write_q <= 1'b0;
            rsp_q   <= RSP_OK;
        end else begin
            rsp_q <= rsp_d;
            if (HREADY) begin
                sel_q   <= addr_sel;
                write_q <= HWRITE;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_mem
            ahb_mem_slave #(
                .WORDS (MEM_WORDS)
            ) u_mem (
                .clk         (clk),
                .reset       (reset),
                .hsel_i      (((addr_sel == SEL_MEM0) || (addr_sel == SEL_MEM1)) &&
                              (addr_sel[0] == 1'(gi))),
                .hready_i    (HREADY),
                .hwrite_i    (HWRITE),
                .hsize_i     (HSIZE),
                .haddr_i     (HADDR[9:0]),
                .hwdata_i    (HWDATA),
                .hrdata_o    (mem_rdata[gi]),
                .hreadyout_o (mem_ready[gi]),
                .hresp_o     (mem_resp[gi])
            );
        end
    endgenerate

    always_comb begin
        rsp_d  = rsp_q;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = 32'h0;
        case (rsp_q)
            RSP_OK: begin
                if (sel_q == SEL_DEFAULT) begin
                    HREADY = 1'b0;
                    HRESP  = HRESP_ERROR;
                    rsp_d  = RSP_ERR2;
                end else if ((sel_q == SEL_MEM0) || (sel_q == SEL_MEM1)) begin
                    HREADY = mem_ready[sel_q[0]];
                    HRESP  = mem_resp[sel_q[0]];
                    if (!write_q) begin
                        HRDATA = mem_rdata[sel_q[0]];
                    end
                end
            end
            RSP_ERR2: begin
                HRESP = HRESP_ERROR;
                rsp_d = RSP_OK;
            end
            default: rsp_d = RSP_OK;
        endcase
    end

endmodule

// File: tb/tb_ahb_lite_mem_subsystem.sv
// Directed table-driven bench for the AHB-Lite memory subsystem, plus a
// hand-written reset-abort sequence.
module tb_ahb_lite_mem_subsystem;
    import ahb_lite_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int checks = 0;
    int failures = 0;

    ahb_lite_mem_subsystem dut (
        .clk    (clk),
        .reset  (reset),
        .HADDR  (HADDR),
        .HWRITE (HWRITE),
        .HSIZE  (HSIZE),
        .HBURST (HBURST),
        .HTRANS (HTRANS),
        .HWDATA (HWDATA),
        .HRDATA (HRDATA),
        .HREADY (HREADY),
        .HRESP  (HRESP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic [1:0] t, input logic w, input logic [2:0] s,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic e, input logic [31:0] rd);
        vec_t v;
        v.trans = t; v.write = w; v.size = s; v.addr = a;
        v.wdata = wd; v.err = e; v.rdata = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    task automatic drive_addr(input logic [1:0] t, input logic w, input logic [2:0] s,
                              input logic [31:0] a);
        HTRANS = t; HWRITE = w; HSIZE = s; HADDR = a;
    endtask

    task automatic check_outputs(input string tag, input logic rdy, input logic rsp,
                                 input logic [31:0] rd);
        chk({tag, " hready"}, {31'h0, HREADY}, {31'h0, rdy});
        chk({tag, " hresp"},  {31'h0, HRESP},  {31'h0, rsp});
        chk({tag, " hrdata"}, HRDATA, rd);
    endtask

    localparam logic [1:0] T_IDLE = HTRANS_IDLE;
    localparam logic [1:0] T_BUSY = HTRANS_BUSY;
    localparam logic [1:0] T_NSEQ = HTRANS_NONSEQ;
    localparam logic [1:0] T_SEQ  = HTRANS_SEQ;
    localparam logic [2:0] S_B = 3'd0;
    localparam logic [2:0] S_H = 3'd1;
    localparam logic [2:0] S_W = 3'd2;

    initial begin
        vecs.push_back(mk(T_IDLE, 0, S_W, 32'h000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(T_IDLE, 0, S_W, 32'h000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(T_IDLE, 0, S_W, 32'h000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(T_NSEQ, 1, S_W, 32'h004, 32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h004, 32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(T_NSEQ, 1, S_B, 32'h405, 32'h0000AA00, 0, 32'h0));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h404, 32'h0,        0, 32'h0000AA00));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h004, 32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(T_NSEQ, 1, S_H, 32'h402, 32'h12340000, 0, 32'h0));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h400, 32'h0,        0, 32'h12340000));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h404, 32'h0,        0, 32'h0000AA00));
        vecs.push_back(mk(T_NSEQ, 1, S_W, 32'h900, 32'h11111111, 1, 32'h0));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h900, 32'h0,        1, 32'h0));
        vecs.push_back(mk(T_NSEQ, 1, S_W, 32'h006, 32'h22222222, 1, 32'h0));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h004, 32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(T_NSEQ, 0, 3'd3, 32'h000, 32'h0,       1, 32'h0));
        vecs.push_back(mk(T_SEQ,  0, S_W, 32'h004, 32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(T_BUSY, 0, S_W, 32'h004, 32'h0,        0, 32'h0));
        vecs.push_back(mk(T_NSEQ, 1, S_H, 32'h001, 32'h33333333, 1, 32'h0));
        vecs.push_back(mk(T_NSEQ, 1, S_B, 32'h7FF, 32'hC3000000, 0, 32'h0));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h7FC, 32'h0,        0, 32'hC3000000));
        vecs.push_back(mk(T_NSEQ, 0, S_B, 32'h7FF, 32'h0,        0, 32'hC3000000));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h800, 32'h0,        1, 32'h0));
        vecs.push_back(mk(T_NSEQ, 0, S_W, 32'h000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(T_IDLE, 0, S_W, 32'h000, 32'h0,        0, 32'h0));

        reset = 1'b1; HBURST = 3'd0; HWDATA = 32'h0;
        drive_addr(T_IDLE, 0, S_W, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b1, 1'b0, 32'h0);
        reset = 1'b0;

        drive_addr(vecs[0].trans, vecs[0].write, vecs[0].size, vecs[0].addr);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            if (vecs[i].err) begin
                check_outputs($sformatf("v%0d err1", i), 1'b0, 1'b1, 32'h0);
            end else begin
                check_outputs($sformatf("v%0d", i), 1'b1, 1'b0, vecs[i].rdata);
            end
            HWDATA = vecs[i].wdata;
            if (i + 1 < vecs.size()) begin
                drive_addr(vecs[i+1].trans, vecs[i+1].write, vecs[i+1].size, vecs[i+1].addr);
            end else begin
                drive_addr(T_IDLE, 0, S_W, 32'h0);
            end
            if (vecs[i].err) begin
                @(posedge clk);
                #1;
                check_outputs($sformatf("v%0d err2", i), 1'b1, 1'b1, 32'h0);
            end
            $display("xfer %0d trans=%0d write=%0b size=%0d addr=0x%03h hrdata=0x%08h",
                     i, vecs[i].trans, vecs[i].write, vecs[i].size, vecs[i].addr, HRDATA);
        end

        // Byte write to 0x010 aborted by reset at the edge ending its data phase.
        drive_addr(T_NSEQ, 1, S_B, 32'h010);
        @(posedge clk);
        #1;
        HWDATA = 32'h00000055;
        reset = 1'b1;
        drive_addr(T_IDLE, 0, S_W, 32'h0);
        @(posedge clk);
        #1;
        check_outputs("rst-mid", 1'b1, 1'b0, 32'h0);
        $display("reset mid-transfer hready=%0b hresp=%0b hrdata=0x%08h", HREADY, HRESP, HRDATA);
        reset = 1'b0;
        drive_addr(T_NSEQ, 0, S_W, 32'h010);
        @(posedge clk);
        #1;
        check_outputs("rd 0x010 after reset", 1'b1, 1'b0, 32'h0);
        $display("read 0x010 hrdata=0x%08h", HRDATA);
        drive_addr(T_NSEQ, 0, S_W, 32'h004);
        @(posedge clk);
        #1;
        check_outputs("rd 0x004 after reset", 1'b1, 1'b0, 32'h0);
        $display("read 0x004 hrdata=0x%08h", HRDATA);
        drive_addr(T_IDLE, 0, S_W, 32'h0);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
